mem_arbiter: RTL and testbench



---
 rtl/mem_arbiter_pkg.sv | 18 +
 rtl/mem_arbiter_if.sv | 48 ++++
 rtl/mem_arbiter_req_latch.sv | 47 ++++
 rtl/mem_arbiter.sv | 149 ++++++++++++++
 tb/tb_mem_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the two-port memory bus arbiter: FSM states, request
// op codes and the default word returned when a read times out.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WR_GAP  = 2'd1,
    ST_RD_WAIT = 2'd2
  } state_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_t;

  localparam logic [31:0] DEAD_WORD_DEF = 32'hDEADBEEF;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two masters, the arbiter and the memory.
// slave = arbiter side, master = environment (masters plus memory).
interface mem_arbiter_if #(parameter int AW = 16);

  logic          p0_rd_en;
  logic          p0_wr_en;
  logic [AW-1:0] p0_addr;
  logic [31:0]   p0_wr_data;
  logic [31:0]   p0_rd_data;
  logic          p0_rd_valid;

  logic          p1_rd_en;
  logic          p1_wr_en;
  logic [AW-1:0] p1_addr;
  logic [31:0]   p1_wr_data;
  logic [31:0]   p1_rd_data;
  logic          p1_rd_valid;

  logic          mem_rd_en;
  logic          mem_wr_en;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wr_data;
  logic [31:0]   mem_rd_data;
  logic          mem_rd_valid;

  logic          drop_err;
  logic          timeout_err;
  logic          err_clr;

  modport slave (
    input  p0_rd_en, p0_wr_en, p0_addr, p0_wr_data,
    input  p1_rd_en, p1_wr_en, p1_addr, p1_wr_data,
    input  mem_rd_data, mem_rd_valid, err_clr,
    output p0_rd_data, p0_rd_valid, p1_rd_data, p1_rd_valid,
    output mem_rd_en, mem_wr_en, mem_addr, mem_wr_data,
    output drop_err, timeout_err
  );

  modport master (
    output p0_rd_en, p0_wr_en, p0_addr, p0_wr_data,
    output p1_rd_en, p1_wr_en, p1_addr, p1_wr_data,
    output mem_rd_data, mem_rd_valid, err_clr,
    input  p0_rd_data, p0_rd_valid, p1_rd_data, p1_rd_valid,
    input  mem_rd_en, mem_wr_en, mem_addr, mem_wr_data,
    input  drop_err, timeout_err
  );

endinterface

// File: rtl/mem_arbiter_req_latch.sv
// One-deep request holder for a master that cannot be stalled. A request may
// be captured on the same edge the held one is granted, so back-to-back
// pulses are never lost.
module mem_arbiter_req_latch
  import mem_arbiter_pkg::*;
#(
  parameter int AW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rd_en,
  input  logic          wr_en,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wr_data,
  input  logic          grant,
  output logic          pending,
  output op_t           op,
  output logic [AW-1:0] addr_q,
  output logic [31:0]   data_q,
  output logic          drop
);

  logic req;
  logic capture;

  assign req     = rd_en | wr_en;
  assign capture = req & (~pending | grant);
  // A simultaneous rd/wr keeps the write but still counts as a lost request.
  assign drop    = (req & pending & ~grant) | (rd_en & wr_en);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= 1'b0;
      op      <= OP_RD;
      addr_q  <= '0;
      data_q  <= '0;
    end else if (capture) begin
      pending <= 1'b1;
      op      <= wr_en ? OP_WR : OP_RD;
      addr_q  <= addr;
      data_q  <= wr_data;
    end else if (grant) begin
      pending <= 1'b0;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory bus between the cpu (port 0) and an
// auxiliary master (port 1); read data is routed back to the owning port.
//
//   state      | meaning
//   ST_IDLE    | bus free, grant a pending latch (round-robin on conflict)
//   ST_WR_GAP  | write pulse issued last edge, enable drops, back to idle
//   ST_RD_WAIT | read issued, wait for mem_rd_valid or the timeout
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int          AW        = 16,
  parameter int          TIMEOUT   = 255,
  parameter logic [31:0] DEAD_WORD = DEAD_WORD_DEF
) (
  input logic           clk,
  input logic           rst_n,
  mem_arbiter_if.slave  bus
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_t        state;
  logic          owner;
  logic          last_grant;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;

  logic [1:0]    pend;
  logic [1:0]    grant;
  logic [1:0]    drop;
  op_t           op [2];
  logic [AW-1:0] addr_q [2];
  logic [31:0]   data_q [2];

  logic          gsel;
  logic          rd_done;
  logic          timeout_hit;
  logic [31:0]   rd_word;

  mem_arbiter_req_latch #(.AW(AW)) u_latch0 (
    .clk     (clk),
    .rst_n   (rst_n),
    .rd_en   (bus.p0_rd_en),
    .wr_en   (bus.p0_wr_en),
    .addr    (bus.p0_addr),
    .wr_data (bus.p0_wr_data),
    .grant   (grant[0]),
    .pending (pend[0]),
    .op      (op[0]),
    .addr_q  (addr_q[0]),
    .data_q  (data_q[0]),
    .drop    (drop[0])
  );

  mem_arbiter_req_latch #(.AW(AW)) u_latch1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .rd_en   (bus.p1_rd_en),
    .wr_en   (bus.p1_wr_en),
    .addr    (bus.p1_addr),
    .wr_data (bus.p1_wr_data),
    .grant   (grant[1]),
    .pending (pend[1]),
    .op      (op[1]),
    .addr_q  (addr_q[1]),
    .data_q  (data_q[1]),
    .drop    (drop[1])
  );

  // last_grant=1 means port 1 was served last, so port 0 wins a tie.
  always_comb begin
    grant = 2'b00;
    if (state == ST_IDLE) begin
      if (pend[0] && (!pend[1] || last_grant)) grant[0] = 1'b1;
      else if (pend[1])                        grant[1] = 1'b1;
    end
  end

  assign gsel        = grant[1];
  assign cnt_next    = cnt + CW'(1);
  assign timeout_hit = (state == ST_RD_WAIT) && !bus.mem_rd_valid &&
                       (cnt_next == CW'(TIMEOUT));
  assign rd_done     = (state == ST_RD_WAIT) &&
                       (bus.mem_rd_valid || (cnt_next == CW'(TIMEOUT)));
  assign rd_word     = bus.mem_rd_valid ? bus.mem_rd_data : DEAD_WORD;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= ST_IDLE;
      owner           <= 1'b0;
      last_grant      <= 1'b1;
      cnt             <= '0;
      bus.mem_rd_en   <= 1'b0;
      bus.mem_wr_en   <= 1'b0;
      bus.mem_addr    <= '0;
      bus.mem_wr_data <= '0;
      bus.p0_rd_valid <= 1'b0;
      bus.p0_rd_data  <= '0;
      bus.p1_rd_valid <= 1'b0;
      bus.p1_rd_data  <= '0;
      bus.drop_err    <= 1'b0;
      bus.timeout_err <= 1'b0;
    end else begin
      bus.mem_rd_en   <= 1'b0;
      bus.mem_wr_en   <= 1'b0;
      bus.p0_rd_valid <= rd_done & ~owner;
      bus.p0_rd_data  <= (rd_done & ~owner) ? rd_word : '0;
      bus.p1_rd_valid <= rd_done & owner;
      bus.p1_rd_data  <= (rd_done & owner) ? rd_word : '0;
      // A new error on the same edge as err_clr stays set.
      bus.drop_err    <= (|drop) | (bus.drop_err & ~bus.err_clr);
      bus.timeout_err <= timeout_hit | (bus.timeout_err & ~bus.err_clr);

      case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (|grant) begin
            bus.mem_addr    <= addr_q[gsel];
            bus.mem_wr_data <= data_q[gsel];
            owner           <= gsel;
            last_grant      <= gsel;
            if (op[gsel] == OP_WR) begin
              bus.mem_wr_en <= 1'b1;
              state         <= ST_WR_GAP;
            end else begin
              bus.mem_rd_en <= 1'b1;
              state         <= ST_RD_WAIT;
            end
          end
        end
        ST_WR_GAP: begin
          state <= ST_IDLE;
        end
        ST_RD_WAIT: begin
          if (rd_done) begin
            cnt   <= '0;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt_next;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized traffic checked
// every cycle against a transaction-level model of the arbiter.
module tb_mem_arbiter;

  localparam int          AW   = 16;
  localparam int          TMO  = 4;
  localparam logic [31:0] DEAD = 32'hDEADBEEF;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if #(.AW(AW)) bus ();

  mem_arbiter #(.AW(AW), .TIMEOUT(TMO), .DEAD_WORD(DEAD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // stimulus registers
  logic [1:0]    r_en, w_en;
  logic [AW-1:0] a_in [2];
  logic [31:0]   d_in [2];
  logic          clr_in;
  logic          m_vld;
  logic [31:0]   m_rdata;

  assign bus.p0_rd_en     = r_en[0];
  assign bus.p0_wr_en     = w_en[0];
  assign bus.p0_addr      = a_in[0];
  assign bus.p0_wr_data   = d_in[0];
  assign bus.p1_rd_en     = r_en[1];
  assign bus.p1_wr_en     = w_en[1];
  assign bus.p1_addr      = a_in[1];
  assign bus.p1_wr_data   = d_in[1];
  assign bus.err_clr      = clr_in;
  assign bus.mem_rd_valid = m_vld;
  assign bus.mem_rd_data  = m_rdata;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit            q_full [2];
  bit            q_wr   [2];
  logic [AW-1:0] q_addr [2];
  logic [31:0]   q_data [2];
  int            rd_owner;   // -1 when no read outstanding
  int            rd_age;
  bit            wr_gap;
  int            last_port;

  bit            e_rd_en, e_wr_en, e_drop, e_tmo;
  logic [AW-1:0] e_addr;
  logic [31:0]   e_wdata;
  bit            e_vld   [2];
  logic [31:0]   e_rdata [2];

  task automatic reset_model();
    for (int p = 0; p < 2; p++) begin
      q_full[p] = 0; e_vld[p] = 0; e_rdata[p] = '0;
    end
    rd_owner = -1; rd_age = 0; wr_gap = 0; last_port = 1;
    e_rd_en = 0; e_wr_en = 0; e_drop = 0; e_tmo = 0;
    e_addr = '0; e_wdata = '0;
  endtask

  task automatic model_step();
    bit new_drop = 0;
    bit new_tmo  = 0;
    int g;
    e_rd_en = 0; e_wr_en = 0;
    e_vld[0] = 0; e_vld[1] = 0;
    if (rd_owner >= 0) begin
      rd_age++;
      if (m_vld || rd_age == TMO) begin
        e_vld[rd_owner]   = 1;
        e_rdata[rd_owner] = m_vld ? m_rdata : DEAD;
        new_tmo  = !m_vld;
        rd_owner = -1;
      end
    end else if (wr_gap) begin
      wr_gap = 0;
    end else if (q_full[0] || q_full[1]) begin
      if (q_full[0] && q_full[1]) g = 1 - last_port;
      else                        g = q_full[0] ? 0 : 1;
      last_port = g;
      q_full[g] = 0;
      e_addr    = q_addr[g];
      if (q_wr[g]) begin
        e_wr_en = 1; e_wdata = q_data[g]; wr_gap = 1;
      end else begin
        e_rd_en = 1; rd_owner = g; rd_age = 0;
      end
    end
    for (int p = 0; p < 2; p++) begin
      if (r_en[p] || w_en[p]) begin
        if (r_en[p] && w_en[p]) new_drop = 1;
        if (!q_full[p]) begin
          q_full[p] = 1; q_wr[p] = w_en[p]; q_addr[p] = a_in[p]; q_data[p] = d_in[p];
        end else begin
          new_drop = 1;
        end
      end
    end
    e_drop = new_drop | (e_drop & !clr_in);
    e_tmo  = new_tmo  | (e_tmo  & !clr_in);
  endtask

  // ---------------- memory side + observation ----------------
  int            due = 0;
  int            mem_lat = 1;
  bit            rand_lat = 0;
  bit            stray_en = 0;
  bit            use_fixed = 0;
  logic [31:0]   fixed_word = '0;
  logic [31:0]   resp_word = '0;

  int            cyc = 0;
  int            n_v0, n_v1, n_mrd, n_mwr;
  logic [31:0]   last_d0, last_d1;
  int            v0_cyc, mrd_cyc;
  int            wr_cyc [$];
  logic [AW-1:0] wr_addr [$];
  int            rd_cyc [$];

  task automatic clear_obs();
    n_v0 = 0; n_v1 = 0; n_mrd = 0; n_mwr = 0;
    last_d0 = '0; last_d1 = '0; v0_cyc = 0; mrd_cyc = 0;
    wr_cyc.delete(); wr_addr.delete(); rd_cyc.delete();
  endtask

  task automatic check_outputs();
    cyc++;
    chk("mem_rd_en", bus.mem_rd_en, e_rd_en);
    chk("mem_wr_en", bus.mem_wr_en, e_wr_en);
    if (e_rd_en || e_wr_en) chk("mem_addr", bus.mem_addr, e_addr);
    if (e_wr_en) chk("mem_wr_data", bus.mem_wr_data, e_wdata);
    chk("p0_rd_valid", bus.p0_rd_valid, e_vld[0]);
    chk("p1_rd_valid", bus.p1_rd_valid, e_vld[1]);
    if (e_vld[0]) chk("p0_rd_data", bus.p0_rd_data, e_rdata[0]);
    if (e_vld[1]) chk("p1_rd_data", bus.p1_rd_data, e_rdata[1]);
    chk("drop_err", bus.drop_err, e_drop);
    chk("timeout_err", bus.timeout_err, e_tmo);
    if (bus.p0_rd_valid) begin n_v0++; last_d0 = bus.p0_rd_data; v0_cyc = cyc; end
    if (bus.p1_rd_valid) begin n_v1++; last_d1 = bus.p1_rd_data; end
    if (bus.mem_rd_en)   begin n_mrd++; mrd_cyc = cyc; rd_cyc.push_back(cyc); end
    if (bus.mem_wr_en)   begin n_mwr++; wr_cyc.push_back(cyc); wr_addr.push_back(bus.mem_addr); end
  endtask

  task automatic mem_side();
    m_vld   = 0;
    m_rdata = $urandom();
    if (bus.mem_rd_en) begin
      due       = rand_lat ? $urandom_range(0, 5) : mem_lat;
      resp_word = use_fixed ? fixed_word : $urandom();
    end else if (due > 0) begin
      due--;
      if (due == 0) begin m_vld = 1; m_rdata = resp_word; end
    end else if (stray_en && $urandom_range(0, 99) < 3) begin
      m_vld = 1;
    end
  endtask

  task automatic tick(input bit r0, input bit w0, input logic [AW-1:0] a0, input logic [31:0] d0,
                      input bit r1, input bit w1, input logic [AW-1:0] a1, input logic [31:0] d1,
                      input bit clr);
    r_en[0] = r0; w_en[0] = w0; a_in[0] = a0; d_in[0] = d0;
    r_en[1] = r1; w_en[1] = w1; a_in[1] = a1; d_in[1] = d1;
    clr_in  = clr;
    @(posedge clk);
    if (rst_n) model_step();
    @(negedge clk);
    check_outputs();
    mem_side();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, '0, '0, 0, 0, '0, '0, 0);
  endtask

  task automatic check_reset_zero();
    chk("rst_mem_addr", bus.mem_addr, '0);
    chk("rst_mem_wr_data", bus.mem_wr_data, '0);
    chk("rst_p0_rd_data", bus.p0_rd_data, '0);
    chk("rst_p1_rd_data", bus.p1_rd_data, '0);
  endtask

  initial begin
    r_en = '0; w_en = '0; clr_in = 0; m_vld = 0; m_rdata = '0;
    for (int p = 0; p < 2; p++) begin a_in[p] = '0; d_in[p] = '0; end
    reset_model();
    clear_obs();

    idle(2);
    check_reset_zero();
    rst_n = 1'b1;

    // simultaneous writes: p0 first, p1 two cycles later
    clear_obs();
    tick(0, 1, 16'h0008, 32'hAAAA0000, 0, 1, 16'h000C, 32'h5555FFFF, 0);
    idle(6);
    chk("t2_nwr", wr_addr.size(), 2);
    if (wr_addr.size() == 2) begin
      chk("t2_first", wr_addr[0], 16'h0008);
      chk("t2_second", wr_addr[1], 16'h000C);
      chk("t2_gap", wr_cyc[1] - wr_cyc[0], 2);
    end
    chk("t2_drop", bus.drop_err, 0);

    // p0 read, memory answers after 3 cycles
    clear_obs();
    mem_lat = 3; use_fixed = 1; fixed_word = 32'h12345678;
    tick(1, 0, 16'h0084, '0, 0, 0, '0, '0, 0);
    idle(9);
    chk("t1_mrd", n_mrd, 1);
    chk("t1_v0", n_v0, 1);
    chk("t1_d0", last_d0, 32'h12345678);
    chk("t1_v1", n_v1, 0);

    // write then read on the next cycle
    clear_obs();
    mem_lat = 2; fixed_word = 32'hCAFE0001;
    tick(0, 1, 16'h0008, 32'h00000011, 0, 0, '0, '0, 0);
    tick(1, 0, 16'h0000, '0, 0, 0, '0, '0, 0);
    idle(8);
    chk("t3_nwr", n_mwr, 1);
    chk("t3_nrd", n_mrd, 1);
    if (wr_cyc.size() == 1 && rd_cyc.size() == 1) chk("t3_order", rd_cyc[0] - wr_cyc[0], 2);
    chk("t3_d0", last_d0, 32'hCAFE0001);
    chk("t3_drop", bus.drop_err, 0);

    // three back-to-back p1 reads against slow memory
    clear_obs();
    mem_lat = 2; use_fixed = 0;
    tick(0, 0, '0, '0, 1, 0, 16'h0100, '0, 0);
    tick(0, 0, '0, '0, 1, 0, 16'h0104, '0, 0);
    tick(0, 0, '0, '0, 1, 0, 16'h0108, '0, 0);
    idle(10);
    chk("t4_drop", bus.drop_err, 1);
    chk("t4_v1", n_v1, 2);
    tick(0, 0, '0, '0, 0, 0, '0, '0, 1);
    idle(1);
    chk("t4_clr", bus.drop_err, 0);

    // memory never answers
    clear_obs();
    mem_lat = 0;
    tick(1, 0, 16'h0200, '0, 0, 0, '0, '0, 0);
    idle(8);
    chk("t5_lat", v0_cyc - mrd_cyc, TMO);
    chk("t5_d0", last_d0, DEAD);
    chk("t5_tmo", bus.timeout_err, 1);
    tick(0, 0, '0, '0, 0, 0, '0, '0, 1);
    idle(1);

    // reset in RD_WAIT, stale response afterwards
    clear_obs();
    mem_lat = 5;
    tick(1, 0, 16'h0300, '0, 0, 0, '0, '0, 0);
    idle(2);
    rst_n = 1'b0;
    reset_model();
    idle(2);
    check_reset_zero();
    rst_n = 1'b1;
    idle(6);
    chk("t6_v0", n_v0, 0);
    mem_lat = 1;
    tick(0, 0, '0, '0, 1, 0, 16'h0304, '0, 0);
    idle(5);
    chk("t6_v1", n_v1, 1);

    // randomized traffic
    rand_lat = 1; stray_en = 1;
    for (int c = 0; c < 1500; c++) begin
      bit rr [2];
      bit ww [2];
      for (int p = 0; p < 2; p++) begin
        int k = $urandom_range(0, 99);
        rr[p] = (k < 15) || (k >= 27 && k < 29);
        ww[p] = (k >= 15 && k < 29);
      end
      tick(rr[0], ww[0], AW'($urandom()), $urandom(),
           rr[1], ww[1], AW'($urandom()), $urandom(),
           ($urandom_range(0, 99) < 4));
    end
    idle(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
